// File: rtl/ext_mem_dual_port_responder.sv
// ext_mem_dual_port_responder
//   Byte-wide external memory slave for the two-channel Mout_* master port.
//   Each channel runs its own IDLE/BUSY/ACK sequencer. Reads and writes complete
//   after READ_DELAY / WRITE_DELAY cycles, signalled by a one-cycle DataRdy pulse.
//   A host preload port fills the backing store before start.
//
//   state | meaning
//   IDLE  | waiting for a request (oe xor we) that falls inside the window
//   BUSY  | request latched, cnt counting toward DELAY-1
//   ACK   | DataRdy high for one cycle, read byte on M_Rdata_ram
//
// Ports
//   clock, reset      rising-edge clock, async active-high reset
//   M_oe_ram/M_we_ram per-channel read / write request
//   M_addr_ram        channel c address at [c*ADDR_W +: ADDR_W]
//   M_Wdata_ram       channel c write byte at [c*8 +: 8]
//   M_data_ram_size   channel c access size in bits at [c*4 +: 4]
//   load_en/addr/data host preload (offset relative to BASE_ADDR)
//   M_Rdata_ram       channel c read byte at [c*8 +: 8], nonzero only in ACK
//   M_DataRdy         per-channel completion pulse
//   err_oe_we         sticky: oe and we seen high together on a channel
module ext_mem_dual_port_responder #(
  parameter int ADDR_W      = 7,
  parameter int MEMSIZE     = 1,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          M_oe_ram,
  input  logic [1:0]          M_we_ram,
  input  logic [2*ADDR_W-1:0] M_addr_ram,
  input  logic [15:0]         M_Wdata_ram,
  input  logic [7:0]          M_data_ram_size,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [7:0]          load_data,
  output logic [15:0]         M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
  output logic                err_oe_we
);

  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY) + 1;
  localparam int IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WRITE_DELAY - 1);
  localparam logic [31:0]      WIN_BASE = 32'(BASE_ADDR);
  localparam logic [31:0]      WIN_SIZE = 32'(MEMSIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  state_t           state   [2];
  logic [CNT_W-1:0] cnt     [2];
  logic [7:0]       rd_byte [2];
  logic [1:0]       lat_rd;

  logic [7:0]       mem [MEMSIZE];

  logic [31:0]      offset   [2];
  logic [IDX_W-1:0] idx      [2];
  logic [7:0]       mask     [2];
  logic [7:0]       rd_now   [2];
  logic [7:0]       wr_merge [2];
  logic [1:0]       in_win;
  logic [1:0]       accept;

  function automatic logic [7:0] size_mask(input logic [3:0] s);
    if (s >= 4'd8) return 8'hFF;
    return 8'((9'd1 << s) - 9'd1);
  endfunction

  // Offset is computed unsigned, so addresses below BASE_ADDR wrap to a huge
  // value and fall out of the window with a single compare.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      offset[c]   = 32'(M_addr_ram[c*ADDR_W +: ADDR_W]) - WIN_BASE;
      in_win[c]   = offset[c] < WIN_SIZE;
      idx[c]      = in_win[c] ? IDX_W'(offset[c]) : '0;
      mask[c]     = size_mask(M_data_ram_size[c*4 +: 4]);
      rd_now[c]   = mem[idx[c]] & mask[c];
      wr_merge[c] = (M_Wdata_ram[c*8 +: 8] & mask[c]) | (mem[idx[c]] & ~mask[c]);
      accept[c]   = !reset && (state[c] == IDLE) &&
                    (M_oe_ram[c] ^ M_we_ram[c]) && in_win[c];
    end
  end

  // Backing store is never reset. Later assignments win: preload first,
  // then channel 0, then channel 1.
  always_ff @(posedge clock) begin
    if (load_en && (32'(load_addr) < WIN_SIZE))
      mem[IDX_W'(load_addr)] <= load_data;
    for (int c = 0; c < 2; c++) begin
      if (accept[c] && M_we_ram[c])
        mem[idx[c]] <= wr_merge[c];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        state[c]   <= IDLE;
        cnt[c]     <= '0;
        rd_byte[c] <= 8'h00;
      end
      lat_rd      <= 2'b00;
      M_Rdata_ram <= 16'h0000;
      M_DataRdy   <= 2'b00;
      err_oe_we   <= 1'b0;
    end else begin
      if (|(M_oe_ram & M_we_ram))
        err_oe_we <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        case (state[c])
          IDLE: begin
            M_DataRdy[c]          <= 1'b0;
            M_Rdata_ram[c*8 +: 8] <= 8'h00;
            cnt[c]                <= '0;
            if (accept[c]) begin
              // Read data is captured now so a same-edge write cannot alter it.
              lat_rd[c]  <= M_oe_ram[c];
              rd_byte[c] <= M_oe_ram[c] ? rd_now[c] : 8'h00;
              if ((M_oe_ram[c] && (READ_DELAY == 1)) ||
                  (M_we_ram[c] && (WRITE_DELAY == 1))) begin
                state[c]              <= ACK;
                M_DataRdy[c]          <= 1'b1;
                M_Rdata_ram[c*8 +: 8] <= M_oe_ram[c] ? rd_now[c] : 8'h00;
              end else begin
                state[c] <= BUSY;
                cnt[c]   <= CNT_W'(1);
              end
            end
          end
          BUSY: begin
            if (cnt[c] == (lat_rd[c] ? RD_LAST : WR_LAST)) begin
              state[c]              <= ACK;
              cnt[c]                <= '0;
              M_DataRdy[c]          <= 1'b1;
              M_Rdata_ram[c*8 +: 8] <= rd_byte[c];
            end else begin
              cnt[c] <= cnt[c] + CNT_W'(1);
            end
          end
          ACK: begin
            state[c]              <= IDLE;
            M_DataRdy[c]          <= 1'b0;
            M_Rdata_ram[c*8 +: 8] <= 8'h00;
          end
          default: begin
            state[c]              <= IDLE;
            cnt[c]                <= '0;
            M_DataRdy[c]          <= 1'b0;
            M_Rdata_ram[c*8 +: 8] <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ext_mem_dual_port_responder.md
Name: ext_mem_dual_port_responder

Overview:
- Synthesizable external-memory slave that sits directly downstream of the HLS-generated top's two-channel master memory port (Mout_* bundle).
- Services byte-wide reads and writes with configurable read and write latency, and returns per-channel data and DataRdy.
- Replaces the behavioural memory logic in simulation benches, and serves as the on-board off-chip memory stand-in for FPGA runs.
- Also provides a host preload port for filling memory before start.

Parameters:
- ADDR_W, 7: address bits per channel.
- MEMSIZE, 1: bytes of backing store (1..2**ADDR_W).
- BASE_ADDR, 0: first address served. Window is [BASE_ADDR, BASE_ADDR+MEMSIZE).
- READ_DELAY, 2: cycles from request presentation to DataRdy for reads (>=1).
- WRITE_DELAY, 1: cycles from request presentation to DataRdy for writes (>=1).

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- M_oe_ram, in, 2: per-channel read request.
- M_we_ram, in, 2: per-channel write request.
- M_addr_ram, in, 2*ADDR_W: channel c address at [c*ADDR_W +: ADDR_W].
- M_Wdata_ram, in, 16: channel c write byte at [c*8 +: 8].
- M_data_ram_size, in, 8: channel c size in bits at [c*4 +: 4].
- load_en, in, 1: host preload write strobe.
- load_addr, in, ADDR_W: preload offset, relative to BASE_ADDR.
- load_data, in, 8: preload byte.
- M_Rdata_ram, out, 16: channel c read byte at [c*8 +: 8].
- M_DataRdy, out, 2: per-channel completion pulse.
- err_oe_we, out, 1: sticky flag, set when oe and we are both high on any channel.

Behaviour:
- Reset: async assert forces M_Rdata_ram=0, M_DataRdy=0, err_oe_we=0, and both channel FSMs to IDLE. Memory contents are not cleared.
- Per-channel FSM:
  - States are IDLE, BUSY, ACK.
  - IDLE -> BUSY at an edge where (oe xor we) is high and the address is in window. The request is latched at that edge; call the cycle it is presented cycle N.
  - BUSY counts with cnt. It goes to ACK when cnt reaches DELAY-1 (DELAY = READ_DELAY or WRITE_DELAY, per the latched type).
  - With DELAY=1, the FSM goes IDLE -> ACK directly.
  - ACK lasts one cycle, then IDLE.
- DataRdy: M_DataRdy[c]=1 only in ACK, i.e. during cycle N+DELAY. It is a one-cycle pulse.
- Requester handshake:
  - The requester holds its request through the ACK cycle.
  - A request still high in the cycle after ACK is a new request.
  - Request inputs are ignored while in BUSY or ACK.
- Read data:
  - The memory byte is sampled at the acceptance edge.
  - M_Rdata_ram[c] shows that byte only during ACK, and 0 otherwise.
  - Masking uses size s: mask=(1<<s)-1 for s<8, and mask=8'hFF for s>=8. Read data is byte&mask.
- Write commit:
  - Commits at the acceptance edge: mem = (wdata&mask) | (mem&~mask).
- Out-of-window: a request outside the window is not accepted. The FSM stays IDLE and DataRdy stays 0; another slave owns that address.
- Channel collisions:
  - Same-edge write on both channels to the same byte: channel 1 wins.
  - Read on one channel and write on the other to the same byte at the same edge: the read returns the old value.
- Preload:
  - load_en writes load_data to offset load_addr at the edge. Offsets >= MEMSIZE are ignored.
  - Preload has lower priority than channel writes to the same byte at the same edge.
- Protocol error: oe=we=1 on a channel sets err_oe_we, which holds until reset. That request is not accepted.
- Reset mid-operation: pending ACKs are dropped. Writes already committed persist.
- Counter width is clog2(max(READ_DELAY,WRITE_DELAY))+1. There is no wrap: cnt returns to 0 in IDLE.

Test Plan:
- Preload offset 0 = 8'hA5. Ch0 oe, addr=0, size=8, held from cycle 10 -> M_DataRdy[0] high only in cycle 12, M_Rdata_ram[7:0]=8'hA5 in cycle 12 and 0 in cycles 11 and 13.
- Ch1 we, addr=0, wdata=8'h3C, size=4, over mem 8'hA5 -> DataRdy[1] pulses in cycle N+1. A following read returns 8'hAC.
- Same edge: ch0 we 8'h11 and ch1 we 8'h22 to addr 0 -> a later read returns 8'h22. Both DataRdy bits pulse together at N+1.
- Same edge: ch0 read and ch1 write 8'h55 to addr 0 (old value 8'hA5) -> ch0 returns 8'hA5. A subsequent read returns 8'h55.
- Ch0 oe=we=1 -> err_oe_we=1 sticky, no DataRdy. Then assert reset -> err_oe_we=0.
- Read at addr BASE_ADDR+MEMSIZE -> no DataRdy for 10 cycles. Assert reset during BUSY of a valid read -> DataRdy never pulses, FSM returns to IDLE.
